// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: opcodes, datapath
// select codes, FSM state encoding and the decoded instruction class.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_R     = 3'b000;
    localparam logic [2:0] IMM_I     = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_LUI   = 3'b101;
    localparam logic [2:0] IMM_AUIPC = 3'b110;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OPIMM   = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_AUIPC   = 4'd3,
        CLS_JAL     = 4'd4,
        CLS_JALR    = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_LOAD    = 4'd7,
        CLS_STORE   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_t;

endpackage

// File: rtl/riscv_op_decode.sv
// Combinational opcode classifier: maps instr[6:0] to an instruction class,
// the immediate-generator select and an illegal-opcode flag.
import riscv_ctrl_pkg::*;

module riscv_op_decode (
    input  logic [6:0]   opcode,
    output instr_class_t cls,
    output logic [2:0]   imm_sel,
    output logic         illegal
);

    // Opcode lookup; anything unlisted is reported illegal.
    always_comb begin
        cls     = CLS_ILLEGAL;
        imm_sel = IMM_R;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI:    begin cls = CLS_LUI;    imm_sel = IMM_LUI;   end
            OPC_AUIPC:  begin cls = CLS_AUIPC;  imm_sel = IMM_AUIPC; end
            OPC_JAL:    begin cls = CLS_JAL;    imm_sel = IMM_J;     end
            OPC_JALR:   begin cls = CLS_JALR;   imm_sel = IMM_I;     end
            OPC_BRANCH: begin cls = CLS_BRANCH; imm_sel = IMM_B;     end
            OPC_LOAD:   begin cls = CLS_LOAD;   imm_sel = IMM_I;     end
            OPC_STORE:  begin cls = CLS_STORE;  imm_sel = IMM_S;     end
            OPC_OPIMM:  begin cls = CLS_OPIMM;  imm_sel = IMM_I;     end
            OPC_OP:     begin cls = CLS_OP;     imm_sel = IMM_R;     end
            default:    begin cls = CLS_ILLEGAL; imm_sel = IMM_R; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V main controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath selects, bus handshakes and a halt-on-fault watchdog.
import riscv_ctrl_pkg::*;

module riscv_mc_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        dmem_err,
    input  logic        br_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout
);

    // The watchdog fires on the cycle whose wait would make the count reach TIMEOUT_CYCLES.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 32'd1);
    localparam logic       WD_EN   = (TIMEOUT_CYCLES != 32'd0);

    state_t       state_r;
    state_t       state_next_s;
    instr_class_t class_r;
    logic [2:0]   imm_sel_r;
    logic         rd_nz_r;
    logic [7:0]   wd_cnt_r;
    logic         illegal_r;
    logic         timeout_r;
    logic         set_ill_s;
    logic         set_to_s;
    logic         wd_hit_s;

    instr_class_t dec_cls_s;
    logic [2:0]   dec_imm_s;
    logic         dec_ill_s;
    logic         unused_instr_hi_s;

    assign unused_instr_hi_s = ^instr[31:12];
    assign wd_hit_s          = WD_EN && (wd_cnt_r == WD_LAST);

    riscv_op_decode u_dec (
        .opcode  (instr[6:0]),
        .cls     (dec_cls_s),
        .imm_sel (dec_imm_s),
        .illegal (dec_ill_s)
    );

    // Next-state selection and fault flag requests.
    always_comb begin
        state_next_s = state_r;
        set_ill_s    = 1'b0;
        set_to_s     = 1'b0;
        case (state_r)
            ST_IDLE: state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next_s = ST_DECODE;
                end else if (wd_hit_s) begin
                    state_next_s = ST_HALT;
                    set_to_s     = 1'b1;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_ill_s) begin
                    state_next_s = ST_HALT;
                    set_ill_s    = 1'b1;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_r)
                    CLS_LOAD, CLS_STORE: state_next_s = ST_MEM;
                    CLS_BRANCH:          state_next_s = ST_FETCH;
                    default:             state_next_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                // A bus error outranks an ack arriving in the same cycle.
                if (dmem_err) begin
                    state_next_s = ST_HALT;
                end else if (dmem_ack) begin
                    state_next_s = (class_r == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (wd_hit_s) begin
                    state_next_s = ST_HALT;
                    set_to_s     = 1'b1;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB:   state_next_s = ST_FETCH;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_HALT;
        endcase
    end

    // State register, sticky fault flags and the decoded-instruction latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            class_r   <= CLS_OP;
            imm_sel_r <= IMM_R;
            rd_nz_r   <= 1'b0;
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (set_ill_s) illegal_r <= 1'b1;
            if (set_to_s)  timeout_r <= 1'b1;
            if (state_r == ST_DECODE) begin
                class_r   <= dec_cls_s;
                imm_sel_r <= dec_imm_s;
                rd_nz_r   <= (instr[11:7] != 5'd0);
            end
        end
    end

    // Watchdog: restarts on every state change, counts while a bus wait is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= 8'd0;
        end else if (state_next_s != state_r) begin
            wd_cnt_r <= 8'd0;
        end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
            wd_cnt_r <= wd_cnt_r + 8'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Datapath selects and strobes decoded from state and latched class.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        imm_sel   = IMM_R;
        alu_src_a = SRCA_RS1;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        case (state_r)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            ST_EXEC: begin
                imm_sel = imm_sel_r;
                case (class_r)
                    CLS_OP:    alu_op = ALU_FUNC;
                    CLS_OPIMM: begin alu_op = ALU_FUNC; alu_src_b = 1'b1; end
                    CLS_LUI:   begin alu_src_a = SRCA_ZERO; alu_src_b = 1'b1; end
                    CLS_AUIPC: begin alu_src_a = SRCA_PC; alu_src_b = 1'b1; end
                    CLS_LOAD, CLS_STORE: alu_src_b = 1'b1;
                    CLS_BRANCH: begin
                        alu_op = ALU_BR;
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? PC_REL : PC_PLUS4;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                imm_sel  = imm_sel_r;
                dmem_req = 1'b1;
                dmem_we  = (class_r == CLS_STORE);
                if ((class_r == CLS_STORE) && dmem_ack && !dmem_err) begin
                    pc_we = 1'b1;
                end else begin
                    pc_we = 1'b0;
                end
            end
            ST_WB: begin
                imm_sel = imm_sel_r;
                rf_we   = rd_nz_r;
                pc_we   = 1'b1;
                case (class_r)
                    CLS_LOAD: wb_sel = WB_LOAD;
                    CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_REL;  end
                    CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
                    default:  begin wb_sel = WB_ALU; pc_sel = PC_PLUS4; end
                endcase
            end
            default: imem_req = 1'b0;
        endcase
    end

    assign state   = state_r;
    assign illegal = illegal_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: a spec-level cycle model checked every
// cycle, plus literal expectations for each instruction scenario.
module tb_riscv_mc_ctrl;

    localparam int TO = 4;

    localparam logic [6:0] M_LUI = 7'b0110111, M_AUIPC = 7'b0010111, M_JAL = 7'b1101111,
                           M_JALR = 7'b1100111, M_BR = 7'b1100011, M_LOAD = 7'b0000011,
                           M_STORE = 7'b0100011, M_OPIMM = 7'b0010011, M_OP = 7'b0110011;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [2:0] imm_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       timeout;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, dmem_err = 1'b0, br_taken = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_b, rf_we, illegal, timeout;
    logic [1:0]  pc_sel, alu_src_a, alu_op, wb_sel;
    logic [2:0]  imm_sel, state;

    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    obs_t obs;
    obs_t log_q[$];

    riscv_mc_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .br_taken(br_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .state(state), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs = '0;
        obs.state = state;         obs.imem_req = imem_req;   obs.dmem_req = dmem_req;
        obs.dmem_we = dmem_we;     obs.ir_we = ir_we;         obs.pc_we = pc_we;
        obs.pc_sel = pc_sel;       obs.imm_sel = imm_sel;     obs.alu_src_a = alu_src_a;
        obs.alu_src_b = alu_src_b; obs.alu_op = alu_op;       obs.rf_we = rf_we;
        obs.wb_sel = wb_sel;       obs.illegal = illegal;     obs.timeout = timeout;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_st = 0;
    int         m_wd = 0;
    logic [6:0] m_opc = 7'd0;
    bit         m_rdnz = 1'b0, m_ill = 1'b0, m_to = 1'b0;

    function automatic bit legal_opc(input logic [6:0] o);
        return o inside {M_LUI, M_AUIPC, M_JAL, M_JALR, M_BR, M_LOAD, M_STORE, M_OPIMM, M_OP};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            M_LUI: return 3'd5;   M_AUIPC: return 3'd6; M_JAL: return 3'd4;
            M_JALR: return 3'd1;  M_BR: return 3'd3;    M_LOAD: return 3'd1;
            M_STORE: return 3'd2; M_OPIMM: return 3'd1; default: return 3'd0;
        endcase
    endfunction

    // Phase numbers follow the published state codes: 0 idle .. 6 halt.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_wd <= 0; m_ill <= 1'b0; m_to <= 1'b0; m_opc <= 7'd0; m_rdnz <= 1'b0;
        end else begin
            case (m_st)
                0: begin m_st <= 1; m_wd <= 0; end
                1: if (imem_ack) m_st <= 2;
                   else if (m_wd + 1 == TO) begin m_st <= 6; m_to <= 1'b1; end
                   else m_wd <= m_wd + 1;
                2: begin
                    m_opc  <= instr[6:0];
                    m_rdnz <= (instr[11:7] != 5'd0);
                    if (!legal_opc(instr[6:0])) begin m_st <= 6; m_ill <= 1'b1; end
                    else m_st <= 3;
                end
                3: begin
                    m_wd <= 0;
                    if (m_opc == M_LOAD || m_opc == M_STORE) m_st <= 4;
                    else if (m_opc == M_BR) m_st <= 1;
                    else m_st <= 5;
                end
                4: if (dmem_err) m_st <= 6;
                   else if (dmem_ack) begin m_st <= (m_opc == M_STORE) ? 1 : 5; m_wd <= 0; end
                   else if (m_wd + 1 == TO) begin m_st <= 6; m_to <= 1'b1; end
                   else m_wd <= m_wd + 1;
                5: begin m_st <= 1; m_wd <= 0; end
                default: m_st <= 6;
            endcase
        end
    end

    function automatic obs_t model_out(input int st, input logic [6:0] opc, input bit rdnz,
                                       input bit ill, input bit to, input logic iack,
                                       input logic dack, input logic derr, input logic brt);
        obs_t o;
        o = '0;
        o.state = 3'(st); o.illegal = ill; o.timeout = to;
        if (st >= 3 && st <= 5) o.imm_sel = imm_of(opc);
        case (st)
            1: begin o.imem_req = 1'b1; o.ir_we = iack; end
            3: case (opc)
                M_OP:    o.alu_op = 2'd2;
                M_OPIMM: begin o.alu_op = 2'd2; o.alu_src_b = 1'b1; end
                M_LUI:   begin o.alu_src_a = 2'd2; o.alu_src_b = 1'b1; end
                M_AUIPC: begin o.alu_src_a = 2'd1; o.alu_src_b = 1'b1; end
                M_LOAD, M_STORE: o.alu_src_b = 1'b1;
                M_BR:    begin o.alu_op = 2'd1; o.pc_we = 1'b1; o.pc_sel = brt ? 2'd1 : 2'd0; end
                default: o.alu_op = 2'd0;
            endcase
            4: begin
                o.dmem_req = 1'b1;
                o.dmem_we  = (opc == M_STORE);
                o.pc_we    = (opc == M_STORE) && dack && !derr;
            end
            5: begin
                o.rf_we = rdnz; o.pc_we = 1'b1;
                if (opc == M_LOAD) o.wb_sel = 2'd1;
                else if (opc == M_JAL) begin o.wb_sel = 2'd2; o.pc_sel = 2'd1; end
                else if (opc == M_JALR) begin o.wb_sel = 2'd2; o.pc_sel = 2'd2; end
            end
            default: o.state = 3'(st);
        endcase
        return o;
    endfunction

    // Per-cycle compare against the model, mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle", 32'(obs),
                  32'(model_out(m_st, m_opc, m_rdnz, m_ill, m_to, imem_ack, dmem_ack, dmem_err, br_taken)));
            log_q.push_back(obs);
        end
    end

    // ---------------- helpers ----------------
    function automatic obs_t find(input int st);
        obs_t r;
        r = '0;
        foreach (log_q[i]) if (log_q[i].state == 3'(st)) r = log_q[i];
        return r;
    endfunction

    function automatic int count_dreq();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].dmem_req) n++;
        return n;
    endfunction

    function automatic int count_pcwe();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].pc_we) n++;
        return n;
    endfunction

    function automatic int count_state(input int st);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].state == 3'(st)) n++;
        return n;
    endfunction

    task automatic wait_for(input bit on_dmem, input string name);
        int n = 0;
        while (((on_dmem ? dmem_req : imem_req) !== 1'b1) && n < 20) begin
            @(posedge clk); #2; n++;
        end
        check(name, 32'(n < 20), 32'd1);
    endtask

    task automatic run(input logic [31:0] ins, input bit brt, input int fdly, input bit use_mem,
                       input int mdly, input bit mack, input bit merr, input bit halts);
        log_q.delete();
        instr = ins;
        br_taken = brt;
        wait_for(1'b0, "wait_fetch");
        repeat (fdly) begin @(posedge clk); #2; end
        imem_ack = 1'b1; @(posedge clk); #2; imem_ack = 1'b0;
        if (use_mem) begin
            wait_for(1'b1, "wait_mem");
            repeat (mdly) begin @(posedge clk); #2; end
            dmem_ack = mack; dmem_err = merr;
            @(posedge clk); #2;
            dmem_ack = 1'b0; dmem_err = 1'b0;
        end
        if (halts) begin
            repeat (3) begin @(posedge clk); #2; end
        end else begin
            wait_for(1'b0, "wait_refetch");
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_flags", {30'd0, illegal, timeout}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #12;
        check("por_state", 32'(state), 32'd0);
        check("por_strobes", {27'd0, imem_req, dmem_req, ir_we, pc_we, rf_we}, 32'd0);
        check("por_flags", {30'd0, illegal, timeout}, 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // addi x1,x0,5 straight out of reset
        run(32'h00500093, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("addi_len", 32'(log_q.size()), 32'd5);
        check("addi_seq", {log_q[0].state, log_q[1].state, log_q[2].state, log_q[3].state, log_q[4].state},
              {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
        check("addi_back", 32'(state), 32'd1);
        check("addi_exec", {find(3).imm_sel, find(3).alu_src_b}, {3'b001, 1'b1});
        check("addi_wb_rf", 32'(find(5).rf_we), 32'd1);

        run(32'hFE000EE3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("beq_t_len", 32'(log_q.size()), 32'd3);
        check("beq_t_exec", {find(3).imm_sel, find(3).pc_we, find(3).pc_sel}, {3'b011, 1'b1, 2'b01});

        run(32'hFE000EE3, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("beq_nt_exec", {find(3).pc_we, find(3).pc_sel}, {1'b1, 2'b00});

        run(32'h0000A103, 1'b0, 1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        check("lw_dreq_cycles", 32'(count_dreq()), 32'd4);
        check("lw_we", 32'(find(4).dmem_we), 32'd0);
        check("lw_wb", {find(5).wb_sel, find(5).rf_we}, {2'b01, 1'b1});
        check("lw_len", 32'(log_q.size()), 32'd9);

        run(32'h008000EF, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("jal", {find(3).imm_sel, find(5).wb_sel, find(5).pc_sel}, {3'b100, 2'b10, 2'b01});
        run(32'h000080E7, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("jalr", {find(5).wb_sel, find(5).pc_sel}, {2'b10, 2'b10});
        run(32'h123450B7, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("lui", {find(3).imm_sel, find(3).alu_src_a, find(3).alu_src_b}, {3'b101, 2'b10, 1'b1});
        run(32'h00001097, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("auipc", {find(3).imm_sel, find(3).alu_src_a}, {3'b110, 2'b01});
        run(32'h002081B3, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("add", {find(3).alu_op, find(3).alu_src_b, find(3).imm_sel}, {2'b10, 1'b0, 3'b000});
        run(32'h00000013, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("addi_x0_rf", 32'(find(5).rf_we), 32'd0);

        run(32'h00112023, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        check("sw_len", 32'(log_q.size()), 32'd4);
        check("sw_mem", {find(4).dmem_we, find(4).pc_we, find(4).pc_sel}, {1'b1, 1'b1, 2'b00});

        run(32'h00112023, 1'b0, 0, 1'b1, 0, 1'b1, 1'b1, 1'b1);
        check("sw_err_halt", 32'(state), 32'd6);
        check("sw_err_no_pcwe", 32'(count_pcwe()), 32'd0);

        pulse_reset();
        run(32'h0000007F, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("ill_seq", {log_q[1].state, log_q[2].state, log_q[3].state}, {3'd1, 3'd2, 3'd6});
        check("ill_flag", 32'(illegal), 32'd1);
        repeat (4) begin @(posedge clk); #2; end
        check("ill_quiet", {27'd0, imem_req, dmem_req, pc_we, rf_we, ir_we}, 32'd0);

        pulse_reset();
        check("ill_cleared", 32'(illegal), 32'd0);
        log_q.delete();
        repeat (8) begin @(posedge clk); #2; end
        check("to_fetch_cycles", 32'(count_state(1)), 32'd4);
        check("to_halt", {29'd0, state}, 32'd6);
        check("to_flag", 32'(timeout), 32'd1);

        pulse_reset();
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("pre_rst_req", 32'(imem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #2; end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
